// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and read-slave state encoding.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } rd_state_t;

endpackage

// File: rtl/timeout_counter.sv
// Saturating wait-cycle counter; flags the last allowed cycle while enabled.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins, then increment while enabled, holding at LAST.
  always_comb begin
    count_d = count_q;
    if (i_clear)
      count_d = '0;
    else if (i_enable && (count_q != LAST))
      count_d = count_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (i_reset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_expired = i_enable && (count_q == LAST);

endmodule

// File: rtl/read_response.sv
// AXI4-Lite read slave: decodes AR, issues one tagged backend read,
// returns data or an error on R. All outputs come straight from flops.
module read_response
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT     = 'h0000_1000,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic                  o_rd_req,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_tag,
  input  logic                  i_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_tag,
  input  logic                  i_rd_err
);

  rd_state_t             state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  logic                  rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_tag_q, rd_tag_d;
  logic                  expired;
  logic                  rsp_hit;

  // Only a response carrying the outstanding tag counts; stale ones are dropped.
  assign rsp_hit = i_rd_valid && (i_rd_tag == rd_tag_q);

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_clear  (state_q == ISSUE),
    .i_enable (state_q == WAIT),
    .o_expired(expired)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_tag_d  = rd_tag_q;
    unique case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (i_arvalid && arready_q) begin
          arready_d = 1'b0;
          if (i_araddr >= ADDR_LIMIT) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = DECERR;
          end else if (i_araddr[1:0] != 2'b00) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = SLVERR;
          end else begin
            // Strobe and address land together in the ISSUE cycle.
            state_d   = ISSUE;
            rd_req_d  = 1'b1;
            rd_addr_d = i_araddr;
            rd_tag_d  = ~rd_tag_q;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A matching response in the final cycle beats the timeout.
        if (rsp_hit) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = i_rd_data;
          rresp_d  = i_rd_err ? SLVERR : OKAY;
        end else if (expired) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = SLVERR;
        end
      end
      RESP: begin
        if (i_rready && rvalid_q) begin
          state_d   = IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_tag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign o_arready = arready_q;
  assign o_rvalid  = rvalid_q;
  assign o_rdata   = rdata_q;
  assign o_rresp   = rresp_q;
  assign o_rd_req  = rd_req_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_tag  = rd_tag_q;

endmodule

// File: tb/tb_read_response.sv
// Directed bench for read_response: latency, decode errors, timeout,
// stale-tag rejection, R backpressure and mid-transaction reset.
module tb_read_response;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_araddr;
  logic        i_arvalid;
  logic        o_arready;
  logic [31:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rvalid;
  logic        i_rready;
  logic        o_rd_req;
  logic [31:0] o_rd_addr;
  logic        o_rd_tag;
  logic        i_rd_valid;
  logic [31:0] i_rd_data;
  logic        i_rd_tag;
  logic        i_rd_err;

  int checks = 0;
  int errors = 0;
  logic exp_tag;

  always #5 clk = ~clk;

  read_response dut (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_araddr  (i_araddr),
    .i_arvalid (i_arvalid),
    .o_arready (o_arready),
    .o_rdata   (o_rdata),
    .o_rresp   (o_rresp),
    .o_rvalid  (o_rvalid),
    .i_rready  (i_rready),
    .o_rd_req  (o_rd_req),
    .o_rd_addr (o_rd_addr),
    .o_rd_tag  (o_rd_tag),
    .i_rd_valid(i_rd_valid),
    .i_rd_data (i_rd_data),
    .i_rd_tag  (i_rd_tag),
    .i_rd_err  (i_rd_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AR handshake; returns one cycle after the accepting edge.
  task automatic do_ar(input logic [31:0] addr);
    int n = 0;
    i_araddr  = addr;
    i_arvalid = 1'b1;
    while (!o_arready && n < 20) begin
      tick();
      n++;
    end
    chk("ar_ready", o_arready, 1'b1);
    tick();
    i_arvalid = 1'b0;
  endtask

  // R handshake, then back to IDLE with arready up.
  task automatic r_hs(input string tag);
    i_rready = 1'b1;
    tick();
    i_rready = 1'b0;
    chk({tag, "_rvalid_clr"}, o_rvalid, 1'b0);
    chk({tag, "_arready_back"}, o_arready, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_arready"}, o_arready, 1'b0);
    chk({tag, "_rvalid"},  o_rvalid,  1'b0);
    chk({tag, "_rdata"},   o_rdata,   32'h0);
    chk({tag, "_rresp"},   o_rresp,   2'b00);
    chk({tag, "_rd_req"},  o_rd_req,  1'b0);
    chk({tag, "_rd_addr"}, o_rd_addr, 32'h0);
    chk({tag, "_rd_tag"},  o_rd_tag,  1'b0);
  endtask

  initial begin
    int n;
    i_reset = 1'b1; i_araddr = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    i_rd_valid = 1'b0; i_rd_data = '0; i_rd_tag = 1'b0; i_rd_err = 1'b0;
    exp_tag = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    i_reset = 1'b0;
    tick();
    chk("rst_arready_up", o_arready, 1'b1);

    // Aligned read 0x10, backend answers 2 cycles after the strobe.
    do_ar(32'h10);
    exp_tag = ~exp_tag;
    chk("rd10_req", o_rd_req, 1'b1);
    chk("rd10_addr", o_rd_addr, 32'h10);
    chk("rd10_tag", o_rd_tag, exp_tag);
    chk("rd10_arready_lo", o_arready, 1'b0);
    tick();
    chk("rd10_req_pulse", o_rd_req, 1'b0);
    chk("rd10_addr_w1", o_rd_addr, 32'h10);
    tick();
    chk("rd10_addr_w2", o_rd_addr, 32'h10);
    chk("rd10_rvalid_early", o_rvalid, 1'b0);
    i_rd_valid = 1'b1; i_rd_data = 32'hCAFE_F00D; i_rd_tag = exp_tag;
    tick();
    i_rd_valid = 1'b0;
    chk("rd10_rvalid", o_rvalid, 1'b1);
    chk("rd10_rdata", o_rdata, 32'hCAFE_F00D);
    chk("rd10_rresp", o_rresp, 2'b00);
    r_hs("rd10");

    // Decode error above the register space.
    do_ar(32'h2000);
    chk("dec_req", o_rd_req, 1'b0);
    chk("dec_rvalid", o_rvalid, 1'b1);
    chk("dec_rresp", o_rresp, 2'b11);
    chk("dec_rdata", o_rdata, 32'h0);
    r_hs("dec");

    // Unaligned address.
    do_ar(32'h12);
    chk("ual_req", o_rd_req, 1'b0);
    chk("ual_rvalid", o_rvalid, 1'b1);
    chk("ual_rresp", o_rresp, 2'b10);
    chk("ual_rdata", o_rdata, 32'h0);
    r_hs("ual");

    // Backend error flag with minimum latency.
    do_ar(32'h40);
    exp_tag = ~exp_tag;
    chk("err_tag", o_rd_tag, exp_tag);
    tick();
    i_rd_valid = 1'b1; i_rd_data = 32'h55; i_rd_tag = exp_tag; i_rd_err = 1'b1;
    tick();
    i_rd_valid = 1'b0; i_rd_err = 1'b0;
    chk("err_rvalid", o_rvalid, 1'b1);
    chk("err_rresp", o_rresp, 2'b10);
    chk("err_rdata", o_rdata, 32'h55);
    r_hs("err");

    // Silent backend: timeout, then 10 cycles of R backpressure.
    do_ar(32'h20);
    exp_tag = ~exp_tag;
    chk("tmo_tag", o_rd_tag, exp_tag);
    tick();
    n = 0;
    while (!o_rvalid && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 64);
    chk("tmo_rresp", o_rresp, 2'b10);
    chk("tmo_rdata", o_rdata, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rvalid", o_rvalid, 1'b1);
      chk("hold_rresp", o_rresp, 2'b10);
      chk("hold_rdata", o_rdata, 32'h0);
      chk("hold_arready", o_arready, 1'b0);
    end
    r_hs("tmo");

    // Stale response with the previous tag is ignored.
    do_ar(32'h30);
    exp_tag = ~exp_tag;
    chk("stl_tag", o_rd_tag, exp_tag);
    tick();
    i_rd_valid = 1'b1; i_rd_data = 32'hDEAD; i_rd_tag = ~exp_tag;
    tick();
    chk("stl_ignored", o_rvalid, 1'b0);
    i_rd_data = 32'h1234; i_rd_tag = exp_tag;
    tick();
    i_rd_valid = 1'b0;
    chk("stl_rvalid", o_rvalid, 1'b1);
    chk("stl_rdata", o_rdata, 32'h1234);
    chk("stl_rresp", o_rresp, 2'b00);
    r_hs("stl");

    // Reset while waiting on the backend; a later response is dropped.
    do_ar(32'h44);
    exp_tag = ~exp_tag;
    chk("mrst_req", o_rd_req, 1'b1);
    tick();
    i_reset = 1'b1;
    tick();
    chk_reset_vals("mrst");
    i_reset = 1'b0;
    i_rd_valid = 1'b1; i_rd_data = 32'hBEEF; i_rd_tag = exp_tag;
    tick();
    chk("mrst_arready", o_arready, 1'b1);
    chk("mrst_no_rvalid", o_rvalid, 1'b0);
    tick();
    i_rd_valid = 1'b0;
    chk("mrst_no_rvalid2", o_rvalid, 1'b0);
    chk("mrst_rdata", o_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
